uart_tx_fifo_feeder: RTL

Byte buffer and issue sequencer that sits directly upstream of the UART transmitter in the Ethernet debug/console path. Producers push bytes into a circular FIFO at any rate up to one per clock. A small FSM pops one byte at a time and presents it to the transmitter with a single-cycle valid pulse. It then tracks the transmitter's busy flag through rise and fall before issuing the next byte, so no byte is dropped or issued twice.

---
 rtl/uart_tx_fifo_feeder_if.sv | 26 ++
 rtl/uart_tx_fifo_feeder.sv | 100 ++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_feeder_if.sv
// Producer / transmitter handshake bundle for the UART TX FIFO feeder.
// master = producer + transmitter side, slave = the feeder itself.
interface uart_tx_fifo_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic                clr_overflow;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_busy;

    modport master (
        output wr_data, wr_en, clr_overflow, tx_busy,
        input  full, empty, level, overflow, tx_data, tx_valid
    );

    modport slave (
        input  wr_data, wr_en, clr_overflow, tx_busy,
        output full, empty, level, overflow, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Circular byte FIFO feeding a UART transmitter: pops one byte, pulses tx_valid,
// then waits for tx_busy to rise and fall before issuing the next.
module uart_tx_fifo_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_fifo_feeder_if.slave  bus
);
    localparam int                  DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  pop;

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);
    // full is taken from the pre-pop level, so a write while full is dropped
    // even when a pop lands on the same edge.
    assign wr_ok = bus.wr_en && !full;
    assign pop   = (state == IDLE) && !empty;

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Set beats clear when both happen on the same edge.
            if (bus.wr_en && full)     overflow <= 1'b1;
            else if (bus.clr_overflow) overflow <= 1'b0;
        end
    end

    // tx_valid is registered off ISSUE, so the pulse lands one edge after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_valid <= 1'b0;
                    if (!empty) begin
                        tx_data <= mem[rd_ptr];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_valid <= 1'b1;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    tx_valid <= 1'b0;
                    if (bus.tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    tx_valid <= 1'b0;
                    if (!bus.tx_busy) state <= IDLE;
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
